sram_test_sequencer: RTL and testbench

Test-pattern sequencer that sits directly upstream of the SRAM controller on the Cmod A7-35T SRAM tester. On command it writes a selectable data pattern to every address in 0..LAST_ADDR, then reads each address back and compares against the expected pattern. It drives the controller's start/rw/address/data inputs and consumes its busy, data-ready and read-data outputs. It reports pass/fail, a saturating error count and the first failing address and data.

---
 rtl/sram_test_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_sram_test_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_test_sequencer.sv
// Write/read-back pattern sequencer driving the SRAM controller handshake.
// Reports pass/fail, a saturating mismatch count and the first failing location.
module sram_test_sequencer #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LAST_ADDR  = 2**19 - 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  test_start,
    input  logic [1:0]            pattern_sel,
    output logic                  start_operation,
    output logic                  rw,
    output logic [ADDR_WIDTH-1:0] address_output,
    output logic [DATA_WIDTH-1:0] data_f2s,
    input  logic                  busy_signal,
    input  logic                  data_ready_signal,
    input  logic [DATA_WIDTH-1:0] data_s2f,
    output logic                  test_busy,
    output logic                  test_done,
    output logic                  test_pass,
    output logic                  timeout_error,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_error_address,
    output logic [DATA_WIDTH-1:0] first_error_data
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [CNT_W-1:0]      TO_LIM = CNT_W'(TIMEOUT - 1);
    localparam logic [15:0]           ERR_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT_BUSY,
        S_WR_WAIT_DONE,
        S_RD_REQ,
        S_RD_WAIT_BUSY,
        S_RD_WAIT_READY,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [1:0]            r_pattern;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_start;
    logic                  r_rw;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_timeout;
    logic [15:0]           r_err_cnt;
    logic [ADDR_WIDTH-1:0] r_first_addr;
    logic [DATA_WIDTH-1:0] r_first_data;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rd_seen;

    state_t                w_state_nxt;
    logic [1:0]            w_pattern_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_start_nxt;
    logic                  w_rw_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_pass_nxt;
    logic                  w_timeout_nxt;
    logic [15:0]           w_err_nxt;
    logic [ADDR_WIDTH-1:0] w_first_addr_nxt;
    logic [DATA_WIDTH-1:0] w_first_data_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_rd_seen_nxt;
    logic                  w_to_hit;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [DATA_WIDTH-1:0] w_expected;

    function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [1:0] sel,
                                                        input logic [ADDR_WIDTH-1:0] a);
        case (sel)
            2'd0:    return DATA_WIDTH'(a[7:0]);
            2'd1:    return a[0] ? DATA_WIDTH'(8'hAA) : DATA_WIDTH'(8'h55);
            2'd2:    return DATA_WIDTH'(8'h00);
            default: return DATA_WIDTH'(~a[7:0]);
        endcase
    endfunction

    assign w_to_hit   = (r_cnt == TO_LIM);
    assign w_last     = (r_addr == LAST);
    assign w_addr_inc = r_addr + ADDR_WIDTH'(1);
    assign w_expected = f_pattern(r_pattern, r_addr);

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        w_state_nxt      = r_state;
        w_pattern_nxt    = r_pattern;
        w_addr_nxt       = r_addr;
        w_start_nxt      = 1'b0;
        w_rw_nxt         = r_rw;
        w_data_nxt       = r_data;
        w_done_nxt       = r_done;
        w_timeout_nxt    = r_timeout;
        w_err_nxt        = r_err_cnt;
        w_first_addr_nxt = r_first_addr;
        w_first_data_nxt = r_first_data;
        w_cnt_nxt        = '0;
        w_rd_seen_nxt    = r_rd_seen;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (test_start && !busy_signal) begin
                    w_pattern_nxt    = pattern_sel;
                    w_err_nxt        = '0;
                    w_first_addr_nxt = '0;
                    w_first_data_nxt = '0;
                    w_timeout_nxt    = 1'b0;
                    w_done_nxt       = 1'b0;
                    w_addr_nxt       = '0;
                    w_start_nxt      = 1'b1;
                    w_rw_nxt         = 1'b0;
                    w_data_nxt       = f_pattern(pattern_sel, '0);
                    w_state_nxt      = S_WR_REQ;
                end
            end
            S_WR_REQ: w_state_nxt = S_WR_WAIT_BUSY;
            S_WR_WAIT_BUSY: begin
                if (busy_signal) begin
                    w_state_nxt = S_WR_WAIT_DONE;
                end else if (w_to_hit) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WR_WAIT_DONE: begin
                if (!busy_signal) begin
                    w_start_nxt = 1'b1;
                    if (w_last) begin
                        w_addr_nxt  = '0;
                        w_rw_nxt    = 1'b1;
                        w_state_nxt = S_RD_REQ;
                    end else begin
                        w_addr_nxt  = w_addr_inc;
                        w_rw_nxt    = 1'b0;
                        w_data_nxt  = f_pattern(r_pattern, w_addr_inc);
                        w_state_nxt = S_WR_REQ;
                    end
                end else if (w_to_hit) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RD_REQ: begin
                w_rd_seen_nxt = 1'b0;
                w_state_nxt   = S_RD_WAIT_BUSY;
            end
            S_RD_WAIT_BUSY: begin
                if (busy_signal) begin
                    w_state_nxt = S_RD_WAIT_READY;
                end else if (w_to_hit) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RD_WAIT_READY: begin
                // Compare once per read; advance only after the controller has also gone idle.
                if (data_ready_signal && !r_rd_seen) begin
                    w_rd_seen_nxt = 1'b1;
                    if (data_s2f != w_expected) begin
                        if (r_err_cnt != ERR_MAX) begin
                            w_err_nxt = r_err_cnt + 16'd1;
                        end
                        if (r_err_cnt == 16'd0) begin
                            w_first_addr_nxt = r_addr;
                            w_first_data_nxt = data_s2f;
                        end
                    end
                end
                if ((data_ready_signal || r_rd_seen) && !busy_signal) begin
                    if (w_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_addr_nxt  = w_addr_inc;
                        w_start_nxt = 1'b1;
                        w_rw_nxt    = 1'b1;
                        w_state_nxt = S_RD_REQ;
                    end
                end else if (w_to_hit) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        w_pass_nxt = w_done_nxt && (w_err_nxt == 16'd0) && !w_timeout_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_pattern    <= '0;
            r_addr       <= '0;
            r_start      <= 1'b0;
            r_rw         <= 1'b1;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
            r_cnt        <= '0;
            r_rd_seen    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pattern    <= w_pattern_nxt;
            r_addr       <= w_addr_nxt;
            r_start      <= w_start_nxt;
            r_rw         <= w_rw_nxt;
            r_data       <= w_data_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_timeout    <= w_timeout_nxt;
            r_err_cnt    <= w_err_nxt;
            r_first_addr <= w_first_addr_nxt;
            r_first_data <= w_first_data_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rd_seen    <= w_rd_seen_nxt;
        end
    end

    assign start_operation     = r_start;
    assign rw                  = r_rw;
    assign address_output      = r_addr;
    assign data_f2s            = r_data;
    assign test_busy           = r_busy;
    assign test_done           = r_done;
    assign test_pass           = r_pass;
    assign timeout_error       = r_timeout;
    assign error_count         = r_err_cnt;
    assign first_error_address = r_first_addr;
    assign first_error_data    = r_first_data;

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Directed bench for sram_test_sequencer with a small SRAM controller model
// that can corrupt reads or stay permanently idle.
module tb_sram_test_sequencer;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          test_start = 1'b0;
    logic [1:0]    pattern_sel = 2'd0;
    logic          start_operation;
    logic          rw;
    logic [AW-1:0] address_output;
    logic [DW-1:0] data_f2s;
    logic          busy_m = 1'b0;
    logic          dr_m = 1'b0;
    logic [DW-1:0] rdata_m = '0;
    logic          test_busy;
    logic          test_done;
    logic          test_pass;
    logic          timeout_error;
    logic [15:0]   error_count;
    logic [AW-1:0] first_error_address;
    logic [DW-1:0] first_error_data;

    // 0 normal, 1 address 5 reads 8'h54, 2 all reads 8'hFF, 3 never busy
    int            mode = 0;
    int            cnt_m = 0;
    logic          op_rw = 1'b0;
    logic [3:0]    op_addr = '0;
    logic [DW-1:0] op_data = '0;
    logic [DW-1:0] mem [0:15];
    int            pulse_total = 0;
    int            n_cmp = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    sram_test_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDR(15), .TIMEOUT(255)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .test_start         (test_start),
        .pattern_sel        (pattern_sel),
        .start_operation    (start_operation),
        .rw                 (rw),
        .address_output     (address_output),
        .data_f2s           (data_f2s),
        .busy_signal        (busy_m),
        .data_ready_signal  (dr_m),
        .data_s2f           (rdata_m),
        .test_busy          (test_busy),
        .test_done          (test_done),
        .test_pass          (test_pass),
        .timeout_error      (timeout_error),
        .error_count        (error_count),
        .first_error_address(first_error_address),
        .first_error_data   (first_error_data)
    );

    // Controller model: busy for 3 cycles after an accepted start; read data with the falling busy.
    always @(posedge clk) begin
        dr_m <= 1'b0;
        if (mode == 3) begin
            busy_m <= 1'b0;
        end else if (!busy_m) begin
            if (start_operation) begin
                busy_m  <= 1'b1;
                cnt_m   <= 3;
                op_rw   <= rw;
                op_addr <= address_output[3:0];
                op_data <= data_f2s;
            end
        end else if (cnt_m == 1) begin
            busy_m <= 1'b0;
            if (op_rw) begin
                dr_m <= 1'b1;
                if (mode == 2)                        rdata_m <= 8'hFF;
                else if (mode == 1 && op_addr == 4'd5) rdata_m <= 8'h54;
                else                                  rdata_m <= mem[op_addr];
            end else begin
                mem[op_addr] <= op_data;
            end
        end else begin
            cnt_m <= cnt_m - 1;
        end
    end

    always @(negedge clk) if (start_operation) pulse_total <= pulse_total + 1;

    task automatic start_and_wait(input logic [1:0] sel, output int cycles);
        @(negedge clk);
        pattern_sel = sel;
        test_start  = 1'b1;
        @(negedge clk);
        test_start  = 1'b0;
        cycles = 0;
        while (!test_done && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        n_cmp++;
        if (cycles >= 2000) begin
            n_fail++;
            $display("FAIL run_done: test_done still %0b after %0d cycles, required 1", test_done, cycles);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({start_operation, rw, test_busy, test_done, test_pass, timeout_error} !== 6'b010000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 010000",
                     {start_operation, rw, test_busy, test_done, test_pass, timeout_error});
        end
        n_cmp++;
        if ({address_output, data_f2s, error_count, first_error_address, first_error_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr %0h data %0h err %0h fa %0h fd %0h required all 0",
                     address_output, data_f2s, error_count, first_error_address, first_error_data);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_clean_pass(input logic [1:0] sel);
        int cyc;
        int p0;
        mode = 0;
        p0 = pulse_total;
        start_and_wait(sel, cyc);
        n_cmp++;
        if ({test_done, test_pass, timeout_error, test_busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL pass_flags_p%0d: done/pass/to/busy %b required 1100", sel,
                     {test_done, test_pass, timeout_error, test_busy});
        end
        n_cmp++;
        if (error_count !== 16'd0) begin
            n_fail++;
            $display("FAIL pass_errcnt_p%0d: got %0d required 0", sel, error_count);
        end
        n_cmp++;
        if (pulse_total - p0 != 32) begin
            n_fail++;
            $display("FAIL pass_pulses_p%0d: got %0d required 32", sel, pulse_total - p0);
        end
    endtask

    task automatic test_stuck_bit();
        int cyc;
        mode = 1;
        start_and_wait(2'd1, cyc);
        n_cmp++;
        if (error_count !== 16'd1) begin
            n_fail++;
            $display("FAIL stuck_errcnt: got %0d required 1", error_count);
        end
        n_cmp++;
        if (first_error_address !== 19'd5 || first_error_data !== 8'h54) begin
            n_fail++;
            $display("FAIL stuck_first: addr %0h data %0h required 5 / 54", first_error_address, first_error_data);
        end
        n_cmp++;
        if ({test_done, test_pass} !== 2'b10) begin
            n_fail++;
            $display("FAIL stuck_pass: done/pass %b required 10", {test_done, test_pass});
        end
        mode = 0;
    endtask

    task automatic test_all_ff();
        int cyc;
        mode = 2;
        start_and_wait(2'd2, cyc);
        n_cmp++;
        if (error_count !== 16'd16) begin
            n_fail++;
            $display("FAIL allff_errcnt: got %0d required 16", error_count);
        end
        n_cmp++;
        if (first_error_address !== 19'd0 || first_error_data !== 8'hFF || test_pass !== 1'b0) begin
            n_fail++;
            $display("FAIL allff_first: addr %0h data %0h pass %0b required 0 / ff / 0",
                     first_error_address, first_error_data, test_pass);
        end
        mode = 0;
    endtask

    task automatic test_timeout();
        int k;
        int p0;
        mode = 3;
        p0 = pulse_total;
        @(negedge clk);
        pattern_sel = 2'd0;
        test_start  = 1'b1;
        @(negedge clk);
        test_start  = 1'b0;
        n_cmp++;
        if (start_operation !== 1'b1) begin
            n_fail++;
            $display("FAIL to_first_pulse: start_operation %0b required 1", start_operation);
        end
        k = 0;
        while (!test_done && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k < 255 || k > 257) begin
            n_fail++;
            $display("FAIL to_latency: done after %0d cycles required 255..257", k);
        end
        n_cmp++;
        if ({timeout_error, test_done, test_pass} !== 3'b110) begin
            n_fail++;
            $display("FAIL to_flags: to/done/pass %b required 110", {timeout_error, test_done, test_pass});
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (pulse_total - p0 != 1) begin
            n_fail++;
            $display("FAIL to_pulses: got %0d required 1", pulse_total - p0);
        end
        mode = 0;
    endtask

    task automatic test_reset_mid_read();
        int  k;
        int  waited;
        bit  prev_busy;
        bit  violation;
        mode = 0;
        @(negedge clk);
        pattern_sel = 2'd3;
        test_start  = 1'b1;
        @(negedge clk);
        test_start  = 1'b0;
        k = 0;
        while (!(rw && address_output == 19'd7 && busy_m && test_busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 2000) begin
            n_fail++;
            $display("FAIL rst_find_rd7: read of address 7 not seen within %0d cycles", k);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({start_operation, rw, test_busy, test_done, address_output, data_f2s} !== {4'b0100, 19'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_async: start/rw/busy/done %b addr %0h data %0h required 0100 / 0 / 0",
                     {start_operation, rw, test_busy, test_done}, address_output, data_f2s);
        end
        @(negedge clk);
        reset_n     = 1'b1;
        pattern_sel = 2'd0;
        test_start  = 1'b1;
        prev_busy = busy_m;
        waited    = 0;
        violation = 1'b0;
        k = 0;
        while (!start_operation && k < 50) begin
            @(negedge clk);
            if (start_operation && (prev_busy || busy_m)) violation = 1'b1;
            if (!start_operation && busy_m) waited++;
            prev_busy = busy_m;
            k++;
        end
        test_start = 1'b0;
        n_cmp++;
        if (violation || waited == 0 || k >= 50) begin
            n_fail++;
            $display("FAIL busy_hold: violation %0b waited %0d cycles k %0d required 0 / >0 / <50",
                     violation, waited, k);
        end
        k = 0;
        while (!test_done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if ({test_done, test_pass, error_count} !== {2'b11, 16'd0}) begin
            n_fail++;
            $display("FAIL rst_rerun: done/pass %b err %0d required 11 / 0", {test_done, test_pass}, error_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_clean_pass(2'd0);
        test_clean_pass(2'd3);
        test_stuck_bit();
        test_all_ff();
        test_timeout();
        test_clean_pass(2'd1);
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
